// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM receive path.
//   state_t      : frame alignment state (HUNT = searching for SOF, RUN = aligned)
//   DEF_DATA_W   : default slot / lane width
//   DEF_NUM_CH   : default slots per frame (power of two, >= 2)
//   DEF_CNT_W    : default delivered-frame counter width
//   SLOT_W       : slot index width for the default frame size
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;
    localparam int SLOT_W     = $clog2(DEF_NUM_CH);

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index register for the TDM demultiplexer.
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset (slot -> 0)
//   clr    in   force slot to 0
//   load1  in   slot 0 accepted this beat: next slot is 1
//   inc    in   advance one slot, wrapping NUM_CH-1 -> 0
//   slot   out  slot index the next accepted beat is written to
// Priority: clr > load1 > inc.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    localparam int SW     = $clog2(NUM_CH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          load1,
    input  logic          inc,
    output logic [SW-1:0] slot
);

    localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SW'(1);
        end else if (inc) begin
            slot <= (slot == LAST) ? '0 : slot + SW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux_1to4.sv
// TDM receive demultiplexer: rebuilds NUM_CH parallel lanes from a
// one-slot-per-beat stream whose slot 0 is flagged by in_sof, tracks frame
// alignment and reports alignment violations.
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   beat present this cycle
//   in_sof     in   beat is slot 0 of a frame (qualified by in_valid)
//   in_data    in   slot payload
//   out_data   out  assembled frame, lane k at [k*DATA_W +: DATA_W]
//   out_valid  out  one-cycle pulse: out_data holds a new frame
//   slot       out  slot index the next accepted beat is written to
//   locked     out  high while aligned (RUN)
//   sync_err   out  one-cycle pulse on an alignment violation
//   frame_cnt  out  number of frames delivered (wraps)
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int SW     = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [DATA_W-1:0]        in_data,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic [SW-1:0]            slot,
    output logic                     locked,
    output logic                     sync_err,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);

    state_t                         state;
    // Lanes 0..NUM_CH-2 of the frame in progress; the last lane is taken
    // straight from in_data when the frame completes.
    logic [(NUM_CH-1)*DATA_W-1:0]   shadow_p0;
    logic                           slot_clr;
    logic                           slot_load1;
    logic                           slot_inc;

    always_comb begin
        slot_clr   = in_valid && !in_sof && (state == RUN) && (slot == '0);
        slot_load1 = in_valid && in_sof;
        slot_inc   = in_valid && !in_sof && (state == RUN) && (slot != '0);
    end

    tdm_slot_counter #(
        .NUM_CH (NUM_CH)
    ) u_slot_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (slot_clr),
        .load1 (slot_load1),
        .inc   (slot_inc),
        .slot  (slot)
    );

    assign locked = (state == RUN);

    // ---- stage p0: shadow capture, frame assembly, alignment FSM ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            shadow_p0 <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (in_valid) begin
                if (in_sof) begin
                    // Any SOF starts a new frame; an SOF that arrives while a
                    // frame is partly collected abandons that partial frame.
                    shadow_p0[DATA_W-1:0] <= in_data;
                    if ((state == RUN) && (slot != '0)) begin
                        sync_err <= 1'b1;
                    end
                    state <= RUN;
                end else if (state == RUN) begin
                    if (slot == '0) begin
                        // Expected an SOF but got a payload beat: lost alignment.
                        sync_err <= 1'b1;
                        state    <= HUNT;
                    end else if (slot == LAST) begin
                        out_data  <= {in_data, shadow_p0};
                        out_valid <= 1'b1;
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end else begin
                        for (int k = 1; k < NUM_CH - 1; k++) begin
                            if (slot == SW'(k)) begin
                                shadow_p0[k*DATA_W +: DATA_W] <= in_data;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Self-checking bench for tdm_demux_1to4 (DATA_W=8, NUM_CH=4, CNT_W=8).
// Table-driven beats with per-beat expected outputs; completed frames are
// pushed to a scoreboard queue and popped by a monitor on out_valid.
module tb_tdm_demux_1to4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic [1:0]  slot;
    logic        locked;
    logic        sync_err;
    logic [7:0]  frame_cnt;

    tdm_demux_1to4 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .slot      (slot),
        .locked    (locked),
        .sync_err  (sync_err),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic        e_ov;
        logic        e_se;
        logic        e_lock;
        logic [1:0]  e_slot;
        logic [31:0] e_word;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  cnt;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_cnt = 8'd0;
    logic [31:0] exp_hold = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic v, input logic s, input logic [7:0] d,
                           input logic e_ov, input logic e_se, input logic e_lock,
                           input logic [1:0] e_slot, input logic [31:0] e_word);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.e_ov = e_ov; r.e_se = e_se;
        r.e_lock = e_lock; r.e_slot = e_slot; r.e_word = e_word;
        tbl.push_back(r);
    endtask

    task automatic push_frame(input logic [31:0] w);
        exp_t e;
        exp_cnt  = exp_cnt + 8'd1;
        e.word   = w;
        e.cnt    = exp_cnt;
        exp_hold = w;
        sbq.push_back(e);
    endtask

    // Scoreboard monitor: every delivered frame must match the oldest expected one.
    always begin
        @(posedge clk);
        #1;
        if (!reset && out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: out_valid with data %h, no frame expected at %0t",
                         out_data, $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_out_data", out_data, e.word);
                chk("sb_frame_cnt", {24'd0, frame_cnt}, {24'd0, e.cnt});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;

        // Test 2: clean frame
        add_vec(1, 1, 8'h11, 0, 0, 1, 2'd1, 32'h0);
        add_vec(1, 0, 8'h22, 0, 0, 1, 2'd2, 32'h0);
        add_vec(1, 0, 8'h33, 0, 0, 1, 2'd3, 32'h0);
        add_vec(1, 0, 8'h44, 1, 0, 1, 2'd0, 32'h44332211);
        add_vec(0, 0, 8'hFF, 0, 0, 1, 2'd0, 32'h0);
        // Test 4: early SOF abandons 11,22; idle beat mid-frame holds slot
        add_vec(1, 1, 8'h11, 0, 0, 1, 2'd1, 32'h0);
        add_vec(1, 0, 8'h22, 0, 0, 1, 2'd2, 32'h0);
        add_vec(1, 1, 8'h55, 0, 1, 1, 2'd1, 32'h0);
        add_vec(1, 0, 8'h66, 0, 0, 1, 2'd2, 32'h0);
        add_vec(0, 1, 8'hEE, 0, 0, 1, 2'd2, 32'h0);
        add_vec(1, 0, 8'h77, 0, 0, 1, 2'd3, 32'h0);
        add_vec(1, 0, 8'h88, 1, 0, 1, 2'd0, 32'h88776655);
        // Test 5: payload at slot 0 loses lock, then relock
        add_vec(1, 0, 8'h99, 0, 1, 0, 2'd0, 32'h0);
        add_vec(1, 1, 8'h01, 0, 0, 1, 2'd1, 32'h0);
        add_vec(1, 0, 8'h02, 0, 0, 1, 2'd2, 32'h0);
        add_vec(1, 0, 8'h03, 0, 0, 1, 2'd3, 32'h0);
        add_vec(1, 0, 8'h04, 1, 0, 1, 2'd0, 32'h04030201);
        // Test 3: drop to HUNT, non-SOF beats dropped silently, then frame
        add_vec(1, 0, 8'h99, 0, 1, 0, 2'd0, 32'h0);
        add_vec(1, 0, 8'hAA, 0, 0, 0, 2'd0, 32'h0);
        add_vec(1, 0, 8'hBB, 0, 0, 0, 2'd0, 32'h0);
        add_vec(1, 1, 8'hA1, 0, 0, 1, 2'd1, 32'h0);
        add_vec(1, 0, 8'hB2, 0, 0, 1, 2'd2, 32'h0);
        add_vec(1, 0, 8'hC3, 0, 0, 1, 2'd3, 32'h0);
        add_vec(1, 0, 8'hD4, 1, 0, 1, 2'd0, 32'hD4C3B2A1);

        // Test 1: reset release, idle
        #12;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_sync_err", {31'd0, sync_err}, 32'd0);
            chk("idle_locked", {31'd0, locked}, 32'd0);
        end
        chk("idle_out_data", out_data, 32'd0);
        chk("idle_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        chk("idle_slot", {30'd0, slot}, 32'd0);

        // Table-driven sequences
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            in_valid = tbl[i].v;
            in_sof   = tbl[i].s;
            in_data  = tbl[i].d;
            if (tbl[i].e_ov) push_frame(tbl[i].e_word);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
            chk($sformatf("vec%0d_sync_err", i), {31'd0, sync_err}, {31'd0, tbl[i].e_se});
            chk($sformatf("vec%0d_locked", i), {31'd0, locked}, {31'd0, tbl[i].e_lock});
            chk($sformatf("vec%0d_slot", i), {30'd0, slot}, {30'd0, tbl[i].e_slot});
            chk($sformatf("vec%0d_out_data", i), out_data, exp_hold);
        end

        // Test 6: async reset mid-frame
        @(negedge clk);
        in_valid = 1'b1; in_sof = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        in_sof = 1'b0; in_data = 8'h5B;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_slot", {30'd0, slot}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        sbq.delete();
        exp_cnt  = 8'd0;
        exp_hold = 32'd0;
        @(negedge clk);
        #2;
        reset = 1'b0;

        // 256 back-to-back frames: frame_cnt wraps, out_valid every 4th clock
        for (int f = 0; f < 256; f++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_sof   = (b == 0);
                in_data  = w[b*8 +: 8];
                if (b == 3) push_frame(w);
                @(posedge clk);
                #1;
                chk("b2b_out_valid", {31'd0, out_valid}, {31'd0, (b == 3)});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        chk("wrap_out_data", out_data, exp_hold);
        chk("sb_drained", sbq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
